// File: rtl/supersonic_ranger_if.sv
// rtl/supersonic_ranger_if.sv - request/result handshake between controller and ranger
interface supersonic_ranger_if;
  logic        trigger;
  logic        triggerSuc;
  logic        valid;
  logic [31:0] distance;

  modport master (output trigger, input triggerSuc, input valid, input distance);
  modport slave  (input trigger, output triggerSuc, output valid, output distance);
endinterface

// File: rtl/supersonic_ranger.sv
// rtl/supersonic_ranger.sv - ultrasonic sensor trigger/echo timer reporting distance in mm
module supersonic_ranger #(
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned CYC_PER_MM     = 291,
  parameter int unsigned RISE_TIMEOUT   = 1_500_000,
  parameter int unsigned MAX_MM         = 4000,
  parameter int unsigned HOLDOFF_CYCLES = 3_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  supersonic_ranger_if.slave ctrl_if,
  output logic               sonic_trig,
  input  logic               sonic_echo
);
  localparam logic [31:0] LP_TRIG_LAST = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] LP_CYC_LAST  = 32'(CYC_PER_MM - 1);
  localparam logic [31:0] LP_RISE_LAST = 32'(RISE_TIMEOUT - 1);
  localparam logic [31:0] LP_MAX_MM    = 32'(MAX_MM);
  localparam logic [31:0] LP_HOLD_LAST = 32'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_HOLDOFF} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_echo_meta, r_echo_s, r_echo_d;
  logic        r_trig_q, r_trig_qq;
  logic        r_pending, r_sonic_trig, r_trig_suc, r_valid;
  logic [31:0] r_distance, r_cnt, r_presc, r_mm;
  logic        w_trig_edge, w_echo_rise, w_echo_fall, w_hold_done;
  logic        w_start, w_cnt_clr, w_suc, w_post, w_oor, w_count_echo;

  assign w_trig_edge = r_trig_q & ~r_trig_qq;
  assign w_echo_rise = r_echo_s & ~r_echo_d;
  assign w_echo_fall = ~r_echo_s & r_echo_d;
  assign w_hold_done = (r_cnt >= LP_HOLD_LAST);

  assign sonic_trig         = r_sonic_trig;
  assign ctrl_if.triggerSuc = r_trig_suc;
  assign ctrl_if.valid      = r_valid;
  assign ctrl_if.distance   = r_distance;

  always_comb begin
    w_state_nxt  = r_state;
    w_start      = 1'b0;
    w_cnt_clr    = 1'b0;
    w_suc        = 1'b0;
    w_post       = 1'b0;
    w_oor        = 1'b0;
    w_count_echo = 1'b0;
    case (r_state)
      S_IDLE: if (w_trig_edge || r_pending) begin
        w_state_nxt = S_TRIG;
        w_start     = 1'b1;
        w_cnt_clr   = 1'b1;
      end
      S_TRIG: if (r_cnt == LP_TRIG_LAST) begin
        w_state_nxt = S_WAIT_RISE;
        w_suc       = 1'b1;
        w_cnt_clr   = 1'b1;
      end
      // The rise cycle itself is echo-high time, so it is counted here
      S_WAIT_RISE: if (w_echo_rise) begin
        w_state_nxt  = S_MEASURE;
        w_count_echo = 1'b1;
        w_cnt_clr    = 1'b1;
      end else if (r_cnt == LP_RISE_LAST) begin
        w_state_nxt = S_HOLDOFF;
        w_post      = 1'b1;
        w_oor       = 1'b1;
        w_cnt_clr   = 1'b1;
      end
      S_MEASURE: if (w_echo_fall) begin
        w_state_nxt = S_HOLDOFF;
        w_post      = 1'b1;
        w_cnt_clr   = 1'b1;
      end else if (r_mm == LP_MAX_MM) begin
        w_state_nxt = S_HOLDOFF;
        w_post      = 1'b1;
        w_oor       = 1'b1;
        w_cnt_clr   = 1'b1;
      end else begin
        w_count_echo = r_echo_s;
      end
      S_HOLDOFF: if (w_hold_done && !r_echo_s) begin
        w_state_nxt = S_IDLE;
        w_cnt_clr   = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Trigger history resets high so a request already asserted at reset release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_echo_meta  <= 1'b0;
      r_echo_s     <= 1'b0;
      r_echo_d     <= 1'b0;
      r_trig_q     <= 1'b1;
      r_trig_qq    <= 1'b1;
      r_pending    <= 1'b0;
      r_sonic_trig <= 1'b0;
      r_trig_suc   <= 1'b0;
      r_valid      <= 1'b0;
      r_distance   <= '0;
      r_cnt        <= '0;
      r_presc      <= '0;
      r_mm         <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_echo_meta  <= sonic_echo;
      r_echo_s     <= r_echo_meta;
      r_echo_d     <= r_echo_s;
      r_trig_q     <= ctrl_if.trigger;
      r_trig_qq    <= r_trig_q;
      r_sonic_trig <= (w_state_nxt == S_TRIG);
      r_trig_suc   <= w_suc;

      if (w_start)
        r_pending <= 1'b0;
      else if (w_trig_edge && r_state != S_IDLE)
        r_pending <= 1'b1;

      if (w_cnt_clr)
        r_cnt <= '0;
      else if (r_state != S_IDLE && r_cnt != '1)
        r_cnt <= r_cnt + 32'd1;

      if (w_start) begin
        r_presc <= '0;
        r_mm    <= '0;
      end else if (w_count_echo) begin
        if (r_presc == LP_CYC_LAST) begin
          r_presc <= '0;
          r_mm    <= r_mm + 32'd1;
        end else begin
          r_presc <= r_presc + 32'd1;
        end
      end

      if (w_start) begin
        r_valid <= 1'b0;
      end else if (w_post) begin
        r_valid    <= 1'b1;
        r_distance <= w_oor ? 32'hFFFF_FFFF : r_mm;
      end
    end
  end
endmodule

// File: tb/tb_supersonic_ranger.sv
// tb/tb_supersonic_ranger.sv - directed self-checking bench for supersonic_ranger
module tb_supersonic_ranger;
  localparam int W_SONIC = 0;
  localparam int W_SUC   = 1;
  localparam int W_VALID = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic sonic_trig;
  logic sonic_echo;
  int   n_tests = 0;
  int   n_fail  = 0;

  supersonic_ranger_if u_if();

  supersonic_ranger #(
    .TRIG_CYCLES(4), .CYC_PER_MM(3), .RISE_TIMEOUT(50), .MAX_MM(100), .HOLDOFF_CYCLES(10)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .ctrl_if(u_if), .sonic_trig(sonic_trig), .sonic_echo(sonic_echo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cond(input int which, input int budget, input string tag, output int n);
    logic hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < budget) begin
      tick();
      n++;
      case (which)
        W_SONIC: hit = sonic_trig;
        W_SUC:   hit = u_if.triggerSuc;
        default: hit = u_if.valid;
      endcase
    end
    check_eq({tag, " reached"}, 32'(hit), 32'd1);
  endtask

  // Returns one cycle after the triggerSuc pulse
  task automatic fire(input string tag);
    int n;
    int hi;
    u_if.trigger = 1'b1;
    wait_cond(W_SONIC, 20, {tag, " trig"}, n);
    check_eq({tag, " trig latency"}, 32'(n), 32'd2);
    check_eq({tag, " valid cleared"}, 32'(u_if.valid), 32'd0);
    u_if.trigger = 1'b0;
    hi = 1;
    do begin
      tick();
      if (sonic_trig) hi++;
    end while (sonic_trig && hi < 20);
    check_eq({tag, " trig width"}, 32'(hi), 32'd4);
    check_eq({tag, " suc at trig fall"}, 32'(u_if.triggerSuc), 32'd1);
    tick();
    check_eq({tag, " suc one cycle"}, 32'(u_if.triggerSuc), 32'd0);
  endtask

  task automatic measure(input int high, input logic [31:0] exp, input string tag);
    int n;
    int bad;
    fire(tag);
    repeat (4) tick();
    sonic_echo = 1'b1;
    repeat (high) tick();
    sonic_echo = 1'b0;
    wait_cond(W_VALID, 20, {tag, " valid"}, n);
    check_eq({tag, " distance"}, u_if.distance, exp);
    bad = 0;
    repeat (20) begin
      tick();
      if (u_if.valid !== 1'b1 || u_if.distance !== exp) bad++;
    end
    check_eq({tag, " held"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    int rises;
    logic prev;

    rst_n        = 1'b0;
    u_if.trigger = 1'b0;
    sonic_echo   = 1'b0;
    repeat (6) begin
      u_if.trigger = 1'($urandom_range(0, 1));
      sonic_echo   = 1'($urandom_range(0, 1));
      tick();
    end
    check_eq("rst sonic_trig", 32'(sonic_trig), 32'd0);
    check_eq("rst triggerSuc", 32'(u_if.triggerSuc), 32'd0);
    check_eq("rst valid", 32'(u_if.valid), 32'd0);
    check_eq("rst distance", u_if.distance, 32'd0);
    u_if.trigger = 1'b0;
    sonic_echo   = 1'b0;
    tick();
    rst_n = 1'b1;
    hi = 0;
    repeat (100) begin
      tick();
      if (sonic_trig) hi++;
    end
    check_eq("idle no trig", 32'(hi), 32'd0);

    measure(30, 32'd10, "nominal");
    measure(32, 32'd10, "trunc32");
    measure(33, 32'd11, "trunc33");

    // Stuck echo, with a request made while it is still high
    fire("stuck");
    repeat (2) tick();
    sonic_echo = 1'b1;
    hi = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (i == 350) u_if.trigger = 1'b1;
      if (i == 352) u_if.trigger = 1'b0;
      if (sonic_trig) hi++;
    end
    check_eq("stuck no retrig", 32'(hi), 32'd0);
    check_eq("stuck valid", 32'(u_if.valid), 32'd1);
    check_eq("stuck distance", u_if.distance, 32'hFFFF_FFFF);
    sonic_echo = 1'b0;
    wait_cond(W_SONIC, 50, "stuck retrig", n);
    check_eq("stuck retrig latency", 32'(n), 32'd4);

    // The pending request runs with no echo and times out
    wait_cond(W_SUC, 20, "noecho suc", n);
    wait_cond(W_VALID, 80, "noecho valid", n);
    check_eq("noecho timeout", 32'(n), 32'd50);
    check_eq("noecho distance", u_if.distance, 32'hFFFF_FFFF);
    repeat (20) tick();

    fire("pending");
    repeat (2) tick();
    sonic_echo = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 5 || i == 10) u_if.trigger = 1'b1;
      if (i == 7 || i == 12) u_if.trigger = 1'b0;
    end
    sonic_echo = 1'b0;
    wait_cond(W_VALID, 20, "pending valid", n);
    check_eq("pending distance", u_if.distance, 32'd10);
    rises = 0;
    prev  = sonic_trig;
    repeat (150) begin
      tick();
      if (sonic_trig && !prev) rises++;
      prev = sonic_trig;
    end
    check_eq("pending one retrig", 32'(rises), 32'd1);
    check_eq("pending 2nd distance", u_if.distance, 32'hFFFF_FFFF);

    // Reset in TRIG, then release with trigger already high
    u_if.trigger = 1'b1;
    wait_cond(W_SONIC, 20, "rstmid trig", n);
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("rstmid sonic_trig", 32'(sonic_trig), 32'd0);
    check_eq("rstmid valid", 32'(u_if.valid), 32'd0);
    check_eq("rstmid distance", u_if.distance, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    hi = 0;
    repeat (20) begin
      tick();
      if (sonic_trig) hi++;
    end
    check_eq("release edge ignored", 32'(hi), 32'd0);
    u_if.trigger = 1'b0;
    tick();
    measure(33, 32'd11, "recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
